// File: rtl/delay_cfg_pkg.sv
// rtl/delay_cfg_pkg.sv - shared types and constants for the delay configuration controller
package delay_cfg_pkg;

  localparam int DELAY_W              = 7;
  localparam int ULTRASOUND_CNT_CYCLE = 512;

  typedef logic [DELAY_W-1:0] delay_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    FLUSH
  } state_t;

endpackage

// File: rtl/delay_table.sv
// rtl/delay_table.sv - shadow/active delay tables with write port, apply strobe and packed output
// Optional DELAY_SAT_EN clamps written values to MAX_DELAY.
module delay_table #(
  parameter int TRANS_NUM = 249,
  parameter int DELAY_W   = 7
`ifdef DELAY_SAT_EN
  ,
  parameter int MAX_DELAY = 127
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [7:0]                   waddr,
  input  logic [DELAY_W-1:0]           wdata,
  input  logic                         apply,
  output logic [TRANS_NUM*DELAY_W-1:0] delay
);
  import delay_cfg_pkg::*;

  localparam logic [8:0] ADDR_LIM = 9'(TRANS_NUM);

  logic [DELAY_W-1:0] shadow [TRANS_NUM];
  logic [DELAY_W-1:0] active [TRANS_NUM];
  logic [DELAY_W-1:0] wdata_eff;
  logic               in_range;

  assign in_range = ({1'b0, waddr} < ADDR_LIM);

`ifdef DELAY_SAT_EN
  localparam logic [DELAY_W-1:0] SAT_VALUE = DELAY_W'(MAX_DELAY);
  assign wdata_eff = (wdata > SAT_VALUE) ? SAT_VALUE : wdata;
`else
  assign wdata_eff = wdata;
`endif

  // Apply copies the pre-edge shadow, so a write on the apply edge waits for the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (we && in_range) begin
        shadow[waddr] <= wdata_eff;
      end
      if (apply) begin
        for (int i = 0; i < TRANS_NUM; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < TRANS_NUM; g++) begin : g_pack
    assign delay[g*DELAY_W +: DELAY_W] = active[g];
  end

endmodule

// File: rtl/delay_cfg_ctrl.sv
// rtl/delay_cfg_ctrl.sv - sequences delay table commits onto ultrasound-cycle boundaries
// Optional DELAY_SAT_EN enables write saturation to MAX_DELAY.
module delay_cfg_ctrl #(
  parameter int TRANS_NUM = 249,
  parameter int DELAY_W   = 7
`ifdef DELAY_SAT_EN
  ,
  parameter int MAX_DELAY = 127
`endif
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         UPDATE,
  input  logic                         WE,
  input  logic [7:0]                   WADDR,
  input  logic [DELAY_W-1:0]           WDATA,
  input  logic                         COMMIT,
  output logic [TRANS_NUM*DELAY_W-1:0] DELAY,
  output logic                         DELAY_RST,
  output logic                         BUSY,
  output logic [7:0]                   COMMIT_CNT
);
  import delay_cfg_pkg::*;

  state_t     state, state_nxt;
  logic       pending, pending_nxt;
  logic       busy, busy_nxt;
  logic       delay_rst, delay_rst_nxt;
  logic [7:0] commit_cnt, commit_cnt_nxt;
  logic       apply;

  delay_table #(
    .TRANS_NUM (TRANS_NUM),
    .DELAY_W   (DELAY_W)
`ifdef DELAY_SAT_EN
    ,
    .MAX_DELAY (MAX_DELAY)
`endif
  ) u_table (
    .clk   (CLK),
    .rst   (RST),
    .we    (WE),
    .waddr (WADDR),
    .wdata (WDATA),
    .apply (apply),
    .delay (DELAY)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pending    <= 1'b0;
      busy       <= 1'b0;
      delay_rst  <= 1'b0;
      commit_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      busy       <= busy_nxt;
      delay_rst  <= delay_rst_nxt;
      commit_cnt <= commit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending;
    busy_nxt       = busy;
    delay_rst_nxt  = delay_rst;
    commit_cnt_nxt = commit_cnt;
    apply          = 1'b0;
    case (state)
      IDLE: begin
        // A coincident UPDATE is ignored here; the apply waits a full period.
        if (COMMIT) begin
          state_nxt = WAIT_SYNC;
          busy_nxt  = 1'b1;
        end
      end
      WAIT_SYNC: begin
        if (UPDATE) begin
          apply         = 1'b1;
          delay_rst_nxt = 1'b1;
          state_nxt     = FLUSH;
        end
      end
      FLUSH: begin
        if (COMMIT) begin
          pending_nxt = 1'b1;
        end
        if (UPDATE) begin
          delay_rst_nxt  = 1'b0;
          commit_cnt_nxt = commit_cnt + 8'd1;
          if (pending || COMMIT) begin
            pending_nxt = 1'b0;
            state_nxt   = WAIT_SYNC;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign DELAY_RST  = delay_rst;
  assign BUSY       = busy;
  assign COMMIT_CNT = commit_cnt;

endmodule

// File: tb/tb_delay_cfg_ctrl.sv
// tb/tb_delay_cfg_ctrl.sv - directed self-checking bench for delay_cfg_ctrl
module tb_delay_cfg_ctrl;
  import delay_cfg_pkg::*;

  localparam int TN = 249;
  localparam int DW = 7;

  logic             CLK = 1'b0;
  logic             RST;
  logic             UPDATE;
  logic             WE;
  logic [7:0]       WADDR;
  logic [DW-1:0]    WDATA;
  logic             COMMIT;
  logic [TN*DW-1:0] DELAY;
  logic             DELAY_RST;
  logic             BUSY;
  logic [7:0]       COMMIT_CNT;

  logic [8:0]       tcnt = '0;
  logic [TN*DW-1:0] exp_vec;
  int               n_checks = 0;
  int               n_fails  = 0;
  int               flush_len;

  delay_cfg_ctrl #(
    .TRANS_NUM (TN),
    .DELAY_W   (DW)
`ifdef DELAY_SAT_EN
    ,
    .MAX_DELAY (100)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .UPDATE     (UPDATE),
    .WE         (WE),
    .WADDR      (WADDR),
    .WDATA      (WDATA),
    .COMMIT     (COMMIT),
    .DELAY      (DELAY),
    .DELAY_RST  (DELAY_RST),
    .BUSY       (BUSY),
    .COMMIT_CNT (COMMIT_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) tcnt <= tcnt + 9'd1;
  assign UPDATE = (tcnt == 9'(ULTRASOUND_CNT_CYCLE - 1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i);
    return 32'(DELAY[i*DW +: DW]);
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_tcnt(input logic [8:0] v);
    int k;
    k = 0;
    while (tcnt !== v && k < 1100) begin
      step();
      k++;
    end
    if (k >= 1100) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_tcnt: timeout waiting for time_cnt %0d", v);
    end
  endtask

  task automatic write(input logic [7:0] a, input logic [DW-1:0] d);
    WE    = 1'b1;
    WADDR = a;
    WDATA = d;
    step();
    WE    = 1'b0;
  endtask

  task automatic commit_pulse();
    COMMIT = 1'b1;
    step();
    COMMIT = 1'b0;
  endtask

  task automatic measure_flush(output int n);
    n = 0;
    while (DELAY_RST === 1'b1 && n < 2000) begin
      n++;
      step();
    end
  endtask

  initial begin
    RST    = 1'b1;
    WE     = 1'b0;
    COMMIT = 1'b0;
    WADDR  = '0;
    WDATA  = '0;
    repeat (3) step();
    check("rst delay_rst", 32'(DELAY_RST), 0);
    check("rst busy", 32'(BUSY), 0);
    check("rst commit_cnt", 32'(COMMIT_CNT), 0);
    check("rst delay zero", 32'(DELAY == '0), 1);
    RST = 1'b0;
    step();

    // basic apply
    write(8'd0, 7'd1);
    write(8'd1, 7'd2);
    wait_tcnt(9'd100);
    commit_pulse();
    check("t1 busy after commit", 32'(BUSY), 1);
    check("t1 delay0 before apply", ent(0), 0);
    wait_tcnt(9'd511);
    check("t1 delay0 at boundary", ent(0), 0);
    check("t1 delay_rst at boundary", 32'(DELAY_RST), 0);
    step();
    check("t1 delay0 applied", ent(0), 1);
    check("t1 delay1 applied", ent(1), 2);
    check("t1 delay_rst high", 32'(DELAY_RST), 1);
    check("t1 busy in flush", 32'(BUSY), 1);
    measure_flush(flush_len);
    check("t1 flush length", 32'(flush_len), 512);
    check("t1 busy released", 32'(BUSY), 0);
    check("t1 commit_cnt", 32'(COMMIT_CNT), 1);

    // commit during flush
    commit_pulse();
    wait_tcnt(9'd511);
    step();
    check("t2 first apply rst", 32'(DELAY_RST), 1);
    check("t2 first apply delay0", ent(0), 1);
    wait_tcnt(9'd200);
    write(8'd0, 7'd7);
    commit_pulse();
    wait_tcnt(9'd511);
    step();
    check("t2 release rst", 32'(DELAY_RST), 0);
    check("t2 busy held", 32'(BUSY), 1);
    check("t2 commit_cnt mid", 32'(COMMIT_CNT), 2);
    check("t2 delay0 not yet", ent(0), 1);
    wait_tcnt(9'd511);
    step();
    check("t2 second apply delay0", ent(0), 7);
    check("t2 second apply rst", 32'(DELAY_RST), 1);
    measure_flush(flush_len);
    check("t2 flush length", 32'(flush_len), 512);
    check("t2 commit_cnt", 32'(COMMIT_CNT), 3);
    check("t2 busy released", 32'(BUSY), 0);

    // COMMIT coincident with UPDATE in IDLE
    write(8'd2, 7'd9);
    wait_tcnt(9'd511);
    commit_pulse();
    check("t3 no apply rst", 32'(DELAY_RST), 0);
    check("t3 busy", 32'(BUSY), 1);
    check("t3 delay2 unchanged", ent(2), 0);
    wait_tcnt(9'd511);
    step();
    check("t3 delay2 applied", ent(2), 9);
    check("t3 apply rst", 32'(DELAY_RST), 1);
    measure_flush(flush_len);
    check("t3 commit_cnt", 32'(COMMIT_CNT), 4);

    // write on the apply edge
    commit_pulse();
    wait_tcnt(9'd511);
    write(8'd3, 7'd5);
    check("t4 delay3 old value", ent(3), 0);
    check("t4 apply rst", 32'(DELAY_RST), 1);
    measure_flush(flush_len);
    check("t4 commit_cnt", 32'(COMMIT_CNT), 5);
    commit_pulse();
    wait_tcnt(9'd511);
    step();
    check("t4 delay3 later commit", ent(3), 5);
    measure_flush(flush_len);
    check("t4 commit_cnt 2", 32'(COMMIT_CNT), 6);

    // out-of-range writes, then reset in flush
    write(8'd250, 7'd33);
    write(8'd255, 7'd44);
    write(8'd249, 7'd55);
    commit_pulse();
    wait_tcnt(9'd511);
    step();
    exp_vec = '0;
    exp_vec[0*DW +: DW] = 7'd7;
    exp_vec[1*DW +: DW] = 7'd2;
    exp_vec[2*DW +: DW] = 7'd9;
    exp_vec[3*DW +: DW] = 7'd5;
    check("t5 table intact", 32'(DELAY == exp_vec), 1);
    check("t5 last entry", ent(TN - 1), 0);
    wait_tcnt(9'd300);
    check("t5 in flush", 32'(DELAY_RST), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5 rst delay zero", 32'(DELAY == '0), 1);
    check("t5 rst delay_rst", 32'(DELAY_RST), 0);
    check("t5 rst busy", 32'(BUSY), 0);
    check("t5 rst commit_cnt", 32'(COMMIT_CNT), 0);

    // saturation or pass-through
    write(8'd5, 7'd120);
    commit_pulse();
    wait_tcnt(9'd511);
    step();
`ifdef DELAY_SAT_EN
    check("t6 saturated", ent(5), 100);
`else
    check("t6 pass-through", ent(5), 120);
`endif
    check("t6 delay0 cleared", ent(0), 0);
    measure_flush(flush_len);
    check("t6 flush length", 32'(flush_len), 512);
    check("t6 commit_cnt", 32'(COMMIT_CNT), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
